// File: rtl/vga_sync_rx.sv
// vga_sync_rx: recovers line/frame timing from an external active-low
// HSYNC/VSYNC pair, locks to 640x480 timing and regenerates de/x/y.
module vga_sync_rx #(
    parameter int H_TOTAL    = 1600,
    parameter int H_PULSE    = 192,
    parameter int H_BACK     = 96,
    parameter int H_DISP     = 1280,
    parameter int V_PULSE    = 2,
    parameter int V_BACK     = 29,
    parameter int V_DISP     = 480,
    parameter int TOL        = 2,
    parameter int LOCK_LINES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic        h_locked,
    output logic [10:0] line_len,
    output logic [10:0] pulse_len,
    output logic        line_start,
    output logic        frame_start,
    output logic        de,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic        err
);

    localparam logic [10:0] CNT_MAX   = 11'h7FF;
    localparam logic [9:0]  VCNT_MAX  = 10'h3FF;
    localparam logic [10:0] LL_MIN    = 11'(H_TOTAL - TOL);
    localparam logic [10:0] LL_MAX    = 11'(H_TOTAL + TOL);
    localparam logic [10:0] PL_MIN    = 11'(H_PULSE - TOL);
    localparam logic [10:0] PL_MAX    = 11'(H_PULSE + TOL);
    localparam logic [10:0] HX0       = 11'(H_PULSE + H_BACK);
    localparam logic [10:0] HX1       = 11'(H_PULSE + H_BACK + H_DISP);
    localparam logic [9:0]  VY0       = 10'(V_PULSE + V_BACK);
    localparam logic [9:0]  VY1       = 10'(V_PULSE + V_BACK + V_DISP);
    localparam logic [2:0]  GOOD_LAST = 3'(LOCK_LINES - 1);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        hs_m_q, hs_s_q, hs_p_q;
    logic        vs_m_q, vs_s_q, vs_p_q;
    logic        hs_fall, hs_rise, vs_fall;
    logic [10:0] hcnt_q, hcnt_d, hcnt_inc;
    logic [9:0]  vcnt_q, vcnt_d;
    logic [2:0]  good_q, good_d;
    logic        vset_q, vset_d;
    logic        vpend_q, vpend_d;
    logic        vstart, line_ok;
    logic [10:0] line_len_q, line_len_d;
    logic [10:0] pulse_len_q, pulse_len_d;
    logic        line_start_q, frame_start_q;
    logic        err_q, err_d;
    logic        de_q, de_d;
    logic [10:0] x_q, x_d;
    logic [9:0]  y_q, y_d;

    assign hs_fall = hs_p_q & ~hs_s_q;
    assign hs_rise = ~hs_p_q & hs_s_q;
    assign vs_fall = vs_p_q & ~vs_s_q;

    always_comb begin
        hcnt_inc = (hcnt_q == CNT_MAX) ? CNT_MAX : hcnt_q + 11'd1;
        line_ok  = (hcnt_inc >= LL_MIN) && (hcnt_inc <= LL_MAX) &&
                   (pulse_len_q >= PL_MIN) && (pulse_len_q <= PL_MAX);
        state_d  = state_q;
        good_d   = good_q;
        err_d    = 1'b0;
        // A fall takes priority over a simultaneous timeout
        if (hs_fall) begin
            unique case (state_q)
                SEARCH: begin
                    state_d = MEASURE;
                    good_d  = '0;
                end
                MEASURE: begin
                    if (line_ok) begin
                        good_d = good_q + 3'd1;
                        if (good_q == GOOD_LAST) state_d = LOCKED;
                    end else begin
                        err_d  = 1'b1;
                        good_d = '0;
                    end
                end
                LOCKED: begin
                    if (!line_ok) begin
                        err_d   = 1'b1;
                        state_d = MEASURE;
                        good_d  = '0;
                    end
                end
                default: begin
                    state_d = SEARCH;
                    good_d  = '0;
                end
            endcase
        end else if (hcnt_q == CNT_MAX) begin
            state_d = SEARCH;
            good_d  = '0;
        end

        hcnt_d      = hs_fall ? '0 : hcnt_inc;
        line_len_d  = hs_fall ? hcnt_inc : line_len_q;
        pulse_len_d = hs_rise ? hcnt_inc : pulse_len_q;

        vstart  = hs_fall & (vpend_q | vs_fall);
        vpend_d = hs_fall ? 1'b0 : (vpend_q | vs_fall);
        vcnt_d  = vcnt_q;
        if (vstart) begin
            vcnt_d = '0;
        end else if (hs_fall && vcnt_q != VCNT_MAX) begin
            vcnt_d = vcnt_q + 10'd1;
        end
        // vcnt is only trusted for de once it was re-anchored while locked
        vset_d = (state_d == LOCKED) & (vset_q | vstart);

        de_d = (state_q == LOCKED) & vset_q &
               (hcnt_q >= HX0) & (hcnt_q < HX1) &
               (vcnt_q >= VY0) & (vcnt_q < VY1);
        x_d  = de_d ? hcnt_q - HX0 : '0;
        y_d  = de_d ? vcnt_q - VY0 : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_m_q        <= 1'b1;
            hs_s_q        <= 1'b1;
            hs_p_q        <= 1'b1;
            vs_m_q        <= 1'b1;
            vs_s_q        <= 1'b1;
            vs_p_q        <= 1'b1;
            state_q       <= SEARCH;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            good_q        <= '0;
            vset_q        <= 1'b0;
            vpend_q       <= 1'b0;
            line_len_q    <= '0;
            pulse_len_q   <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            err_q         <= 1'b0;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
        end else begin
            hs_m_q        <= hsync_in;
            hs_s_q        <= hs_m_q;
            hs_p_q        <= hs_s_q;
            vs_m_q        <= vsync_in;
            vs_s_q        <= vs_m_q;
            vs_p_q        <= vs_s_q;
            state_q       <= state_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            good_q        <= good_d;
            vset_q        <= vset_d;
            vpend_q       <= vpend_d;
            line_len_q    <= line_len_d;
            pulse_len_q   <= pulse_len_d;
            line_start_q  <= hs_fall;
            frame_start_q <= vs_fall;
            err_q         <= err_d;
            de_q          <= de_d;
            x_q           <= x_d;
            y_q           <= y_d;
        end
    end

    assign h_locked    = (state_q == LOCKED);
    assign line_len    = line_len_q;
    assign pulse_len   = pulse_len_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign err         = err_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;

endmodule

// File: tb/tb_vga_sync_rx.sv
// tb_vga_sync_rx: random/directed HSYNC/VSYNC streams checked every cycle
// against a line/frame timing model, plus literal checkpoints.
module tb_vga_sync_rx;

    localparam int VP = 2;
    localparam int VB = 2;
    localparam int VD = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic        h_locked;
    logic [10:0] line_len, pulse_len;
    logic        line_start, frame_start, de, err;
    logic [10:0] x;
    logic [9:0]  y;

    vga_sync_rx #(.V_PULSE(VP), .V_BACK(VB), .V_DISP(VD)) dut (
        .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .h_locked(h_locked), .line_len(line_len), .pulse_len(pulse_len),
        .line_start(line_start), .frame_start(frame_start), .de(de),
        .x(x), .y(y), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        hl;
        logic [10:0] ll;
        logic [10:0] pl;
        logic        ls;
        logic        fs;
        logic        er;
    } o2_t;

    typedef struct packed {
        logic        de;
        logic [10:0] x;
        logic [9:0]  y;
    } o3_t;

    int n_chk = 0;
    int n_pass = 0;
    bit armed = 0;

    // model state: position since last fall, measured lengths, lock status
    int pos, llen, plen, good, vcnt;
    bit synced, locked, vpend, vset, prev_h, prev_v;
    o2_t p2 [2];
    o3_t p3 [3];
    o2_t cur2;
    o3_t cur3;

    task automatic model_init();
        pos = 2; llen = 0; plen = 0; good = 0; vcnt = 0;
        synced = 0; locked = 0; vpend = 0; vset = 0;
        prev_h = 1; prev_v = 1;
        p2[0] = '0; p2[1] = '0; cur2 = '0;
        p3[0] = '0; p3[1] = '0; p3[2] = '0; cur3 = '0;
    endtask

    task automatic model_step(input logic h, input logic v);
        o2_t n2;
        o3_t n3;
        bit hf, hr, vf, vreset, ok;
        n2 = '0;
        n3 = '0;
        vreset = 0;
        hf = prev_h && !h;
        hr = !prev_h && h;
        vf = prev_v && !v;
        if (vf) begin
            vpend = 1;
            n2.fs = 1;
        end
        if (hr) plen = (pos + 1 > 2047) ? 2047 : pos + 1;
        if (hf) begin
            n2.ls = 1;
            llen = (pos + 1 > 2047) ? 2047 : pos + 1;
            ok = (llen >= 1598 && llen <= 1602 && plen >= 190 && plen <= 194);
            if (!synced) begin
                synced = 1;
                good = 0;
            end else if (ok) begin
                if (!locked) begin
                    good++;
                    if (good == 4) locked = 1;
                end
            end else begin
                n2.er = 1;
                locked = 0;
                good = 0;
            end
            pos = 0;
            if (vpend) begin
                vcnt = 0;
                vpend = 0;
                vreset = 1;
            end else if (vcnt < 1023) begin
                vcnt++;
            end
        end else begin
            if (pos == 2047) begin
                synced = 0;
                locked = 0;
                good = 0;
            end
            if (pos < 2047) pos++;
        end
        if (!locked) vset = 0;
        else if (vreset) vset = 1;
        n2.hl = locked;
        n2.ll = 11'(llen);
        n2.pl = 11'(plen);
        if (locked && vset && pos >= 288 && pos < 1568 &&
            vcnt >= VP + VB && vcnt < VP + VB + VD) begin
            n3.de = 1;
            n3.x = 11'(pos - 288);
            n3.y = 10'(vcnt - (VP + VB));
        end
        prev_h = h;
        prev_v = v;
        cur2 = p2[1];
        p2[1] = p2[0];
        p2[0] = n2;
        cur3 = p3[2];
        p3[2] = p3[1];
        p3[1] = p3[0];
        p3[0] = n3;
    endtask

    initial begin
        model_init();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_init();
            else model_step(hsync_in, vsync_in);
        end
    end

    // monitor counters
    int ls_cnt = 0, fs_cnt = 0, err_cnt = 0, de_cnt = 0;
    int first_x = -1, first_y = -1, last_x = -1, last_y = -1;
    int ls_at_lock = -1;
    bit prev_lock = 0;

    initial begin
        o2_t d2;
        o3_t d3;
        forever begin
            @(negedge clk);
            if (!reset && armed) begin
                d2 = '{h_locked, line_len, pulse_len, line_start, frame_start, err};
                d3 = '{de, x, y};
                n_chk++;
                if (d2 === cur2 && d3 === cur3) n_pass++;
                else $display("FAIL cycle_cmp t=%0t dut=%h/%h expected=%h/%h",
                              $time, d2, d3, cur2, cur3);
                if (line_start) ls_cnt++;
                if (frame_start) fs_cnt++;
                if (err) err_cnt++;
                if (de) begin
                    if (de_cnt == 0) begin
                        first_x = int'(x);
                        first_y = int'(y);
                    end
                    de_cnt++;
                    last_x = int'(x);
                    last_y = int'(y);
                end
                if (h_locked && !prev_lock && ls_at_lock < 0) ls_at_lock = ls_cnt;
                prev_lock = h_locked;
            end
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    logic vlev = 1'b1;

    task automatic drive_cycle(input logic h);
        @(posedge clk);
        #1;
        hsync_in = h;
        vsync_in = vlev;
    endtask

    task automatic send_line(input int len, input int pw, input bit vlo);
        for (int i = 0; i < len; i++) begin
            if (i == 5) vlev = ~vlo;
            drive_cycle(i >= pw);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b1);
    endtask

    task automatic good_lines(input int n);
        for (int i = 0; i < n; i++) send_line(1600, 192, 0);
    endtask

    function automatic int outs_nonzero();
        return (|{h_locked, line_len, pulse_len, line_start, frame_start,
                  de, x, y, err}) ? 1 : 0;
    endfunction

    int e0;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs_zero", outs_nonzero(), 0);
        reset = 1'b0;
        armed = 1;
        idle(10);

        good_lines(5);
        check("lock_after_5th_fall", ls_at_lock, 5);
        check("locked_ideal", int'(h_locked), 1);
        check("line_len_ideal", int'(line_len), 1600);
        check("pulse_len_ideal", int'(pulse_len), 192);
        check("no_err_ideal", err_cnt, 0);

        de_cnt = 0;
        fs_cnt = 0;
        for (int f = 0; f < 9; f++) send_line(1600, 192, f < 2);
        check("frame_start_once", fs_cnt, 1);
        check("de_cycles", de_cnt, 1280 * VD);
        check("first_x", first_x, 0);
        check("first_y", first_y, 0);
        check("last_x", last_x, 1279);
        check("last_y", last_y, VD - 1);

        e0 = err_cnt;
        send_line(1603, 192, 0);
        good_lines(1);
        check("err_long_line", err_cnt - e0, 1);
        check("unlock_long_line", int'(h_locked), 0);
        good_lines(3);
        check("not_yet_relocked", int'(h_locked), 0);
        good_lines(1);
        check("relock_long_line", int'(h_locked), 1);
        e0 = err_cnt;
        send_line(1602, 192, 0);
        good_lines(1);
        check("no_err_1602", err_cnt - e0, 0);
        check("line_len_1602", int'(line_len), 1602);
        check("locked_1602", int'(h_locked), 1);

        e0 = err_cnt;
        send_line(1600, 195, 0);
        good_lines(1);
        check("err_wide_pulse", err_cnt - e0, 1);
        check("unlock_wide_pulse", int'(h_locked), 0);
        good_lines(4);
        check("relock_wide_pulse", int'(h_locked), 1);
        e0 = err_cnt;
        send_line(1600, 194, 0);
        good_lines(1);
        check("no_err_194", err_cnt - e0, 0);
        check("locked_194", int'(h_locked), 1);

        e0 = err_cnt;
        idle(3000);
        check("timeout_unlock", int'(h_locked), 0);
        check("timeout_no_err", err_cnt - e0, 0);
        good_lines(5);
        check("relock_after_timeout", int'(h_locked), 1);

        for (int i = 0; i < 3; i++)
            send_line($urandom_range(1604, 1596), $urandom_range(196, 188), 0);
        good_lines(5);
        check("locked_before_reset", int'(h_locked), 1);

        idle(20);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("midreset_outputs_zero", outs_nonzero(), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        ls_cnt = 0;
        idle(100);
        check("no_line_start_after_reset", ls_cnt, 0);
        good_lines(2);
        check("line_starts_after_reset", ls_cnt, 2);
        idle(10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
